can_crc_tx: RTL and testbench
=============================

// Module: can_crc_tx
// PURPOSE
//  Transmit-side CAN CRC-15 unit. It accumulates the CRC over the unstuffed frame bits (SOF..end of data) as the
//  serializer sends them, then takes the TX line and shifts out the 15 CRC bits MSB first. It then drives the
//  recessive CRC delimiter and ACK slot, and checks the bus for a dominant ACK and a recessive ACK delimiter.
//  It sits between the frame serializer/bit-stuffer and the TX pin mux, and pairs with the receive-side CRC checker.
// PARAMETERS
//  CRC_W     15        CRC width (fixed by CAN; not intended to change)
//  CRC_POLY  15'h4599  generator x^15+x^14+x^10+x^8+x^7+x^4+x^3+1
// PORTS
//  clk          in   1   system clock (single clock domain; all regs on posedge clk)
//  RST          in   1   synchronous, active-high reset
//  bitstrobe    in   1   1-clk pulse: current bus bit completes this cycle
//  bitstuff     in   1   qualifies bitstrobe: current bit is a stuff bit (excluded from CRC/count)
//  SOF          in   1   with bitstrobe: SOF bit of a new frame being sent
//  tx_bit       in   1   bit the serializer is sending (valid at bitstrobe)
//  last_data    in   1   with bitstrobe: tx_bit is the last data-field bit
//  abort        in   1   arbitration lost / error frame: drop frame
//  CANRX        in   1   sampled bus value (valid at bitstrobe)
//  crc_drive    out  1   block owns TX line (CRC, delimiter, ACK slot, ACK delimiter)
//  crc_txbit    out  1   bit to send while crc_drive=1; 1 otherwise (recessive)
//  crc_value    out  15  current CRC register (debug/observe)
//  crc_done     out  1   1-clk pulse at end of ACK delimiter
//  ack_error    out  1   1-clk pulse: ACK slot sampled recessive
//  delim_error  out  1   1-clk pulse: CRC or ACK delimiter sampled dominant
// BEHAVIOUR
//  - All state updates happen on posedge clk. Clock gating is not allowed: bitstrobe acts as a clock enable.
//  - Let adv = bitstrobe & ~bitstuff. bitstuff is honoured only in ACCUM and SHIFT; from DELIM on it is ignored.
//  - Reset: state=IDLE, crc=0, cnt=0, crc_drive=0, crc_txbit=1, crc_done/ack_error/delim_error=0.
//  - Step: inv=b^crc[14]; crc_next = {crc[13:0],1'b0} ^ (inv ? CRC_POLY : 0).
//  - FSM (one transition per qualifying strobe):
//    IDLE:      SOF&bitstrobe -> crc=0, ACCUM. The SOF bit is dominant and does not change the CRC.
//               SOF outside IDLE is ignored.
//    ACCUM:     on adv, crc=step(tx_bit). If last_data also: cnt=14, go SHIFT (the final step is included).
//    SHIFT:     crc_drive=1, crc_txbit=crc[14]. On adv: crc<<=1, cnt--. When adv arrives with cnt==0 -> DELIM.
//               A stuff-bit strobe holds both crc and cnt.
//    DELIM:     crc_drive=1, crc_txbit=1. On bitstrobe: if CANRX=0, pulse delim_error. Go ACK_SLOT.
//    ACK_SLOT:  crc_drive=1, crc_txbit=1. On bitstrobe: if CANRX=1, pulse ack_error. Go ACK_DLM.
//    ACK_DLM:   crc_drive=1, crc_txbit=1. On bitstrobe: if CANRX=0, pulse delim_error. Pulse crc_done. Go IDLE.
//  - crc_drive and crc_txbit are registered outputs and change in the cycle after the transition.
//    The SHIFT bit is valid from the clk after the ACCUM->SHIFT strobe.
//  - Error pulses and crc_done are registered and asserted for exactly the cycle after the causing strobe.
//  - abort (any state): next state IDLE, crc_drive=0, crc_txbit=1, no pulses. crc is held until the next SOF.
//    Priority: RST > abort > FSM.
//  - Simultaneous SOF+last_data in IDLE: SOF wins, last_data ignored. bitstrobe is never asserted on back-to-back clks.
//  - RST mid-frame returns to the reset state on the next edge. No partial CRC survives.
// STRUCTURE
//  - Shared package can_pkg holds: crc_tx_state_t enum (IDLE, ACCUM, SHIFT, DELIM, ACK_SLOT, ACK_DLM),
//    CAN_CRC_POLY, and CAN_RECESSIVE=1 / CAN_DOMINANT=0.
//  - One sub-module, can_crc15_step (combinational: crc_in, bit -> crc_out). The receive-side checker shares it.
// TESTING
//  1. SOF, tx_bit=1 with last_data -> crc_value=15'h4599. SHIFT emits 100010110011001 over 15 strobes, then DELIM.
//  2. SOF, 8 data bits all 0 + last_data -> crc=0. Emits 15 zeros. crc_drive=1 through ACK_DLM. crc_done once.
//  3. Case 1 with bitstuff on the 3rd and 9th SHIFT strobes -> the sequence is unchanged and takes 17 strobes.
//  4. ACK slot CANRX=0 -> no ack_error. CANRX=1 -> ack_error=1 for one clk. CANRX=0 in DELIM -> delim_error pulse.
//  5. abort at SHIFT cnt=7 -> next clk crc_drive=0, crc_txbit=1, state IDLE. A later SOF starts cleanly from crc=0.
//  6. RST asserted mid-ACCUM for 1 clk -> all outputs at reset values. Subsequent SOF/strobes are ignored until SOF.

Source files
------------

// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared CAN definitions for the CRC-15 transmit and receive paths
package can_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    SHIFT,
    DELIM,
    ACK_SLOT,
    ACK_DLM
  } crc_tx_state_t;

  localparam int          CAN_CRC_W     = 15;
  localparam logic [14:0] CAN_CRC_POLY  = 15'h4599;
  localparam logic        CAN_RECESSIVE = 1'b1;
  localparam logic        CAN_DOMINANT  = 1'b0;

endpackage

// File: rtl/can_crc15_step.sv
// rtl/can_crc15_step.sv - one combinational CAN CRC-15 step, shared by TX and RX CRC units
module can_crc15_step
  import can_pkg::*;
(
  input  logic [CAN_CRC_W-1:0] crc_in,
  input  logic                 data_bit,
  output logic [CAN_CRC_W-1:0] crc_out
);

  logic w_inv;

  assign w_inv   = data_bit ^ crc_in[CAN_CRC_W-1];
  assign crc_out = {crc_in[CAN_CRC_W-2:0], 1'b0} ^ (w_inv ? CAN_CRC_POLY : '0);

endmodule

// File: rtl/can_crc_tx.sv
// rtl/can_crc_tx.sv - transmit CRC-15: accumulates frame bits, shifts CRC out, drives delimiter/ACK and checks them
module can_crc_tx
  import can_pkg::*;
(
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 bitstrobe,
  input  logic                 bitstuff,
  input  logic                 SOF,
  input  logic                 tx_bit,
  input  logic                 last_data,
  input  logic                 abort,
  input  logic                 CANRX,
  output logic                 crc_drive,
  output logic                 crc_txbit,
  output logic [CAN_CRC_W-1:0] crc_value,
  output logic                 crc_done,
  output logic                 ack_error,
  output logic                 delim_error
);

  crc_tx_state_t        r_state, w_state_nxt;
  logic [CAN_CRC_W-1:0] r_crc, w_crc_nxt, w_crc_step;
  logic [3:0]           r_cnt, w_cnt_nxt;
  logic                 r_drive, r_txbit, r_done, r_ack_err, r_delim_err;
  logic                 w_done_nxt, w_ack_nxt, w_delim_nxt;
  logic                 w_drive_nxt, w_txbit_nxt;
  logic                 w_adv;

  can_crc15_step u_step (
    .crc_in   (r_crc),
    .data_bit (tx_bit),
    .crc_out  (w_crc_step)
  );

  assign w_adv = bitstrobe & ~bitstuff;

  always_comb begin
    w_state_nxt = r_state;
    w_crc_nxt   = r_crc;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_ack_nxt   = 1'b0;
    w_delim_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        // SOF is dominant and never enters the CRC; it only clears it
        if (bitstrobe && SOF) begin
          w_crc_nxt   = '0;
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (w_adv) begin
          w_crc_nxt = w_crc_step;
          if (last_data) begin
            w_cnt_nxt   = 4'd14;
            w_state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (w_adv) begin
          w_crc_nxt = {r_crc[CAN_CRC_W-2:0], 1'b0};
          if (r_cnt == 4'd0) begin
            w_state_nxt = DELIM;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
      end
      DELIM: begin
        if (bitstrobe) begin
          w_delim_nxt = (CANRX == CAN_DOMINANT);
          w_state_nxt = ACK_SLOT;
        end
      end
      ACK_SLOT: begin
        if (bitstrobe) begin
          w_ack_nxt   = (CANRX == CAN_RECESSIVE);
          w_state_nxt = ACK_DLM;
        end
      end
      ACK_DLM: begin
        if (bitstrobe) begin
          w_delim_nxt = (CANRX == CAN_DOMINANT);
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // abort leaves the CRC visible for debug until the next SOF clears it
    if (abort) begin
      w_state_nxt = IDLE;
      w_crc_nxt   = r_crc;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      w_ack_nxt   = 1'b0;
      w_delim_nxt = 1'b0;
    end

    w_drive_nxt = (w_state_nxt != IDLE) && (w_state_nxt != ACCUM);
    w_txbit_nxt = (w_state_nxt == SHIFT) ? w_crc_nxt[CAN_CRC_W-1] : CAN_RECESSIVE;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state     <= IDLE;
      r_crc       <= '0;
      r_cnt       <= '0;
      r_drive     <= 1'b0;
      r_txbit     <= CAN_RECESSIVE;
      r_done      <= 1'b0;
      r_ack_err   <= 1'b0;
      r_delim_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_crc       <= w_crc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_drive     <= w_drive_nxt;
      r_txbit     <= w_txbit_nxt;
      r_done      <= w_done_nxt;
      r_ack_err   <= w_ack_nxt;
      r_delim_err <= w_delim_nxt;
    end
  end

  assign crc_drive   = r_drive;
  assign crc_txbit   = r_txbit;
  assign crc_value   = r_crc;
  assign crc_done    = r_done;
  assign ack_error   = r_ack_err;
  assign delim_error = r_delim_err;

endmodule

// File: tb/tb_can_crc_tx.sv
// tb/tb_can_crc_tx.sv - scoreboard bench for can_crc_tx with hand-computed CRC vectors
module tb_can_crc_tx;

  typedef struct {
    int          id;
    logic        drive;
    logic        txbit;
    logic        done;
    logic        ack;
    logic        delim;
    logic        chk;
    logic [14:0] crc;
  } exp_t;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic        bitstrobe = 1'b0;
  logic        bitstuff = 1'b0;
  logic        SOF = 1'b0;
  logic        tx_bit = 1'b0;
  logic        last_data = 1'b0;
  logic        abort = 1'b0;
  logic        CANRX = 1'b1;
  logic        crc_drive;
  logic        crc_txbit;
  logic [14:0] crc_value;
  logic        crc_done;
  logic        ack_error;
  logic        delim_error;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_issued = 0;
  int   drain_cnt = 0;
  logic seen = 1'b0;
  logic prev_seen = 1'b0;
  logic stim_done = 1'b0;

  logic [14:0] seq_a;
  logic [14:0] seq_b;
  logic [16:0] stuff_mask;

  can_crc_tx dut (
    .clk         (clk),
    .RST         (RST),
    .bitstrobe   (bitstrobe),
    .bitstuff    (bitstuff),
    .SOF         (SOF),
    .tx_bit      (tx_bit),
    .last_data   (last_data),
    .abort       (abort),
    .CANRX       (CANRX),
    .crc_drive   (crc_drive),
    .crc_txbit   (crc_txbit),
    .crc_value   (crc_value),
    .crc_done    (crc_done),
    .ack_error   (ack_error),
    .delim_error (delim_error)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex(input logic d, input logic t, input logic dn, input logic a, input logic dl);
    exp_t e;
    e.id = 0; e.drive = d; e.txbit = t; e.done = dn; e.ack = a; e.delim = dl;
    e.chk = 1'b0; e.crc = '0;
    return e;
  endfunction

  function automatic exp_t exc(input logic d, input logic t, input logic [14:0] c);
    exp_t e;
    e = ex(d, t, 1'b0, 1'b0, 1'b0);
    e.chk = 1'b1; e.crc = c;
    return e;
  endfunction

  task automatic strobe(input logic sof, input logic b, input logic last, input logic stuff,
                        input logic rx, input exp_t e);
    exp_t ee;
    @(negedge clk);
    SOF = sof; tx_bit = b; last_data = last; bitstuff = stuff; CANRX = rx; bitstrobe = 1'b1;
    ee = e; ee.id = n_issued; n_issued++;
    exp_q.push_back(ee);
    @(negedge clk);
    bitstrobe = 1'b0; SOF = 1'b0; last_data = 1'b0; bitstuff = 1'b0;
  endtask

  task automatic do_abort(input exp_t e);
    exp_t ee;
    @(negedge clk);
    abort = 1'b1;
    ee = e; ee.id = n_issued; n_issued++;
    exp_q.push_back(ee);
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic do_rst();
    exp_t ee;
    @(negedge clk);
    RST = 1'b1;
    ee = exc(1'b0, 1'b1, 15'h0); ee.id = n_issued; n_issued++;
    exp_q.push_back(ee);
    @(negedge clk);
    RST = 1'b0;
  endtask

  task automatic shift_out(input logic [14:0] seq, input logic [16:0] mask);
    int cur;
    int s;
    cur = 14;
    s = 0;
    while (cur >= 0) begin
      if (mask[s]) begin
        strobe(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, ex(1'b1, seq[cur], 1'b0, 1'b0, 1'b0));
      end else begin
        cur--;
        if (cur >= 0) strobe(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(1'b1, seq[cur], 1'b0, 1'b0, 1'b0));
        else          strobe(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exc(1'b1, 1'b1, 15'h0));
      end
      s++;
    end
  endtask

  task automatic tail(input logic rx_d, input logic rx_a, input logic rx_ad, input logic stuff);
    strobe(1'b0, 1'b0, 1'b0, stuff, rx_d,  ex(1'b1, 1'b1, 1'b0, 1'b0, ~rx_d));
    strobe(1'b0, 1'b0, 1'b0, stuff, rx_a,  ex(1'b1, 1'b1, 1'b0, rx_a, 1'b0));
    strobe(1'b0, 1'b0, 1'b0, stuff, rx_ad, ex(1'b0, 1'b1, 1'b1, 1'b0, ~rx_ad));
  endtask

  always @(posedge clk) seen <= bitstrobe | abort | RST;

  always @(negedge clk) begin
    if (seen) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event at %0t: output event with no expectation queued", $time);
      end else begin
        mon_e = exp_q.pop_front();
        if ({crc_drive, crc_txbit, crc_done, ack_error, delim_error} !==
            {mon_e.drive, mon_e.txbit, mon_e.done, mon_e.ack, mon_e.delim})
          $display("FAIL ev%0d drive/txbit/done/ack/delim got %b%b%b%b%b required %b%b%b%b%b",
                   mon_e.id, crc_drive, crc_txbit, crc_done, ack_error, delim_error,
                   mon_e.drive, mon_e.txbit, mon_e.done, mon_e.ack, mon_e.delim);
        else
          n_pass++;
        if (mon_e.chk) begin
          n_total++;
          if (crc_value !== mon_e.crc)
            $display("FAIL ev%0d crc_value got %h required %h", mon_e.id, crc_value, mon_e.crc);
          else
            n_pass++;
        end
      end
    end else if (prev_seen) begin
      n_total++;
      if ({crc_done, ack_error, delim_error} !== 3'b000)
        $display("FAIL pulse_width done/ack/delim got %b required 000 at %0t",
                 {crc_done, ack_error, delim_error}, $time);
      else
        n_pass++;
    end
    prev_seen <= seen;

    if (stim_done && !seen) begin
      if (exp_q.size() == 0) begin
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
      end else if (drain_cnt > 20) begin
        n_total++;
        $display("FAIL drain pending expectations got %0d required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
      end
      drain_cnt++;
    end
  end

  initial begin
    seq_a = 15'h4599;
    seq_b = 15'h4EAB;

    // frame with single data bit 1, clean ACK
    do_rst();
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exc(1'b0, 1'b1, 15'h0));
    strobe(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, exc(1'b1, seq_a[14], 15'h4599));
    shift_out(seq_a, 17'h0);
    tail(1'b1, 1'b0, 1'b1, 1'b0);

    // SOF with last_data in IDLE, then eight zero bits
    strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, exc(1'b0, 1'b1, 15'h0));
    for (int i = 0; i < 7; i++)
      strobe(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, exc(1'b1, 1'b0, 15'h0));
    shift_out(15'h0, 17'h0);
    tail(1'b1, 1'b0, 1'b1, 1'b1);

    // stuff bits on 3rd and 9th SHIFT strobes, then bad delimiters and missing ACK
    stuff_mask = 17'b0_0000_0001_0000_0100;
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exc(1'b0, 1'b1, 15'h0));
    strobe(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, exc(1'b1, seq_a[14], 15'h4599));
    shift_out(seq_a, stuff_mask);
    tail(1'b0, 1'b1, 1'b0, 1'b0);

    // data 1,0 with a SOF ignored in ACCUM and a stuff bit that must not enter the CRC
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exc(1'b0, 1'b1, 15'h0));
    strobe(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, exc(1'b0, 1'b1, 15'h4599));
    strobe(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, exc(1'b0, 1'b1, 15'h4599));
    strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, exc(1'b1, seq_b[14], 15'h4EAB));
    shift_out(seq_b, 17'h0);
    tail(1'b1, 1'b0, 1'b1, 1'b0);

    // abort at SHIFT cnt=7, then a clean frame
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exc(1'b0, 1'b1, 15'h0));
    strobe(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, exc(1'b1, seq_a[14], 15'h4599));
    for (int k = 1; k <= 7; k++)
      strobe(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ex(1'b1, seq_a[14-k], 1'b0, 1'b0, 1'b0));
    do_abort(exc(1'b0, 1'b1, 15'h4C80));
    strobe(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, exc(1'b0, 1'b1, 15'h4C80));
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exc(1'b0, 1'b1, 15'h0));
    strobe(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, exc(1'b1, seq_a[14], 15'h4599));
    shift_out(seq_a, 17'h0);
    tail(1'b1, 1'b0, 1'b1, 1'b0);

    // reset in the middle of ACCUM
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exc(1'b0, 1'b1, 15'h0));
    strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exc(1'b0, 1'b1, 15'h4599));
    strobe(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exc(1'b0, 1'b1, 15'h4EAB));
    do_rst();
    strobe(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, exc(1'b0, 1'b1, 15'h0));
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exc(1'b0, 1'b1, 15'h0));
    strobe(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, exc(1'b1, seq_a[14], 15'h4599));
    shift_out(seq_a, 17'h0);
    tail(1'b1, 1'b0, 1'b1, 1'b0);

    stim_done = 1'b1;
  end

endmodule
